// File: rtl/clc_apb_master.sv
// ---------------------------------------------------------------------------
// clc_apb_master
//   APB master that runs one CLC encode transaction per accepted start:
//   it writes the data word to BASE_ADDR+0, reads the low 32 bits of the
//   codeword from BASE_ADDR+4 and the high 8 bits from BASE_ADDR+8.
//   The three transfers run back-to-back with PSEL held high.
//
// Ports
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   start, data_in       request an encode of data_in (ignored while busy)
//   busy                 high in every state except IDLE
//   done                 one-cycle pulse while in FIN
//   status               0 ok, 1 slave error, 2 timeout, 3 format error
//   codeword             last good result {high byte, low word}
//   PADDR..PWRITE        registered APB master outputs
//   PRDATA, PREADY, PSLVERR  APB slave responses
// ---------------------------------------------------------------------------
module clc_apb_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        start,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [39:0] codeword,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_ACCESS, R1_SETUP, R1_ACCESS, R2_SETUP, R2_ACCESS, FIN
  } state_t;

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] low_reg;
  logic        in_access;
  logic        go_fin;

  assign in_access = (state == W_ACCESS) || (state == R1_ACCESS) || (state == R2_ACCESS);

  // Every way out of an access phase that ends the transaction: slave error,
  // successful completion of the last read, or the TIMEOUT-th wait cycle.
  assign go_fin = in_access &&
                  (PREADY ? (PSLVERR || (state == R2_ACCESS))
                          : (wait_cnt == TIMEOUT_M1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      wait_cnt <= '0;
      low_reg  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      status   <= 2'd0;
      codeword <= '0;
      PADDR    <= '0;
      PWDATA   <= '0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= W_SETUP;
            status  <= 2'd0;
            busy    <= 1'b1;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b1;
            PADDR   <= BASE_ADDR;
            // PWDATA doubles as the captured data register
            PWDATA  <= {16'h0000, data_in};
          end
        end
        W_SETUP: begin
          state    <= W_ACCESS;
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
        end
        R1_SETUP: begin
          state    <= R1_ACCESS;
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
        end
        R2_SETUP: begin
          state    <= R2_ACCESS;
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
        end
        W_ACCESS, R1_ACCESS, R2_ACCESS: begin
          if (!PREADY) begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == TIMEOUT_M1) status <= 2'd2;
          end else if (PSLVERR) begin
            status <= 2'd1;
          end else if (state == W_ACCESS) begin
            state   <= R1_SETUP;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            PADDR   <= BASE_ADDR + 32'd4;
          end else if (state == R1_ACCESS) begin
            low_reg <= PRDATA;
            state   <= R2_SETUP;
            PENABLE <= 1'b0;
            PADDR   <= BASE_ADDR + 32'd8;
          end else if (|PRDATA[31:8]) begin
            status <= 2'd3;
          end else begin
            // The high register is the top byte of codeword itself; it is
            // committed together with the low word only on a clean finish.
            codeword <= {PRDATA[7:0], low_reg};
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (go_fin) begin
        state   <= FIN;
        done    <= 1'b1;
        PSEL    <= 1'b0;
        PENABLE <= 1'b0;
        PWRITE  <= 1'b0;
        PADDR   <= '0;
        PWDATA  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_clc_apb_master.sv
// ---------------------------------------------------------------------------
// tb_clc_apb_master
//   Directed and randomized transactions against an APB slave model. The
//   expected outcome of each transaction (status, codeword, latency, list of
//   transfers, access-phase cycle count) is computed from the transfer rules
//   with plain arithmetic over the slave configuration.
// ---------------------------------------------------------------------------
module tb_clc_apb_master;
  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam int          TO   = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        start;
  logic [15:0] data_in;
  logic        busy, done;
  logic [1:0]  status;
  logic [39:0] codeword;
  logic [31:0] PADDR, PWDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PRDATA  = '0;
  logic        PREADY  = 1'b0;
  logic        PSLVERR = 1'b0;

  clc_apb_master #(.BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .status(status), .codeword(codeword),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  // slave configuration per transfer index (0 write, 1 low read, 2 high read)
  int          cfg_wait [3];
  bit          cfg_err  [3];
  logic [31:0] cfg_rd   [3];

  // monitor state, written only by the slave/monitor process
  int          acc_cnt   = 0;
  int          acc_total = 0;
  int          unstable  = 0;
  int          fin_bad   = 0;
  int          n_xfer    = 0;
  logic [31:0] xf_addr = '0, xf_wdata = '0;
  logic        xf_write = 1'b0;
  logic [31:0] log_addr  [0:1023];
  logic [31:0] log_wdata [0:1023];
  logic        log_write [0:1023];

  // expected values
  logic [1:0]  exp_status;
  logic [39:0] exp_cw;
  int          exp_lat, exp_nx, exp_acc;

  // APB slave and monitor, sampled and driven on the falling edge
  always @(negedge PCLK) begin
    int idx;
    logic [31:0] off;
    if (PSEL && PENABLE) begin
      acc_total++;
      if (PADDR !== xf_addr || PWDATA !== xf_wdata || PWRITE !== xf_write) unstable++;
      off = PADDR - BASE;
      idx = (off[3:2] > 2'd2) ? 0 : int'(off[3:2]);
      if (acc_cnt < cfg_wait[idx]) begin
        acc_cnt++;
        PREADY  = 1'b0;
        PSLVERR = $urandom_range(0, 1);
        PRDATA  = $urandom;
      end else begin
        PREADY  = 1'b1;
        PSLVERR = cfg_err[idx];
        PRDATA  = cfg_rd[idx];
      end
    end else begin
      acc_cnt = 0;
      PREADY  = $urandom_range(0, 1);
      PSLVERR = $urandom_range(0, 1);
      PRDATA  = $urandom;
      if (PSEL && n_xfer < 1024) begin
        xf_addr  = PADDR;
        xf_wdata = PWDATA;
        xf_write = PWRITE;
        log_addr[n_xfer]  = PADDR;
        log_wdata[n_xfer] = PWDATA;
        log_write[n_xfer] = PWRITE;
        n_xfer++;
      end
    end
    if (done && (PSEL || PENABLE)) fin_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int w0, input int w1, input int w2,
                         input bit e0, input bit e1, input bit e2,
                         input logic [31:0] r1, input logic [31:0] r2);
    cfg_wait[0] = w0; cfg_wait[1] = w1; cfg_wait[2] = w2;
    cfg_err[0]  = e0; cfg_err[1]  = e1; cfg_err[2]  = e2;
    cfg_rd[0]   = $urandom; cfg_rd[1] = r1; cfg_rd[2] = r2;
  endtask

  // Outcome of one transaction: walk write, read-low, read-high in order and
  // stop at the first timeout or slave error.
  task automatic model_txn();
    exp_status = 2'd0; exp_nx = 0; exp_acc = 0; exp_lat = 1;
    for (int i = 0; i < 3; i++) begin
      exp_nx++;
      if (cfg_wait[i] >= TO) begin
        exp_acc += TO; exp_lat += 1 + TO; exp_status = 2'd2; break;
      end
      exp_acc += cfg_wait[i] + 1;
      exp_lat += 2 + cfg_wait[i];
      if (cfg_err[i]) begin exp_status = 2'd1; break; end
      if (i == 2 && cfg_rd[2][31:8] != 24'h0) exp_status = 2'd3;
    end
    if (exp_status == 2'd0) exp_cw = {cfg_rd[2][7:0], cfg_rd[1]};
  endtask

  task automatic run_txn(input string name, input logic [15:0] d, input bit poke);
    int n0, a0, u0, f0, k;
    model_txn();
    n0 = n_xfer; a0 = acc_total; u0 = unstable; f0 = fin_bad;
    start = 1'b1; data_in = d;
    @(negedge PCLK);                       // just after the accepting edge N
    chk({name, "_busy_on"}, busy, 1);
    chk({name, "_status_clr"}, status, 0);
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      start = poke && (k == 1);            // a start while busy must be ignored
      data_in = $urandom;
      @(negedge PCLK);
      k++;
    end
    start = 1'b0;
    chk({name, "_done_seen"}, done, 1);
    // done is high in the cycle that ends at edge N+k+1
    chk({name, "_latency"}, k + 1, exp_lat);
    chk({name, "_status"}, status, exp_status);
    chk({name, "_codeword"}, codeword, exp_cw);
    chk({name, "_busy_fin"}, busy, 1);
    chk({name, "_psel_fin"}, {PSEL, PENABLE}, 0);
    @(negedge PCLK);
    chk({name, "_done_pulse"}, {done, busy}, 0);
    chk({name, "_status_hold"}, status, exp_status);
    chk({name, "_nxfer"}, n_xfer - n0, exp_nx);
    for (int i = 0; i < exp_nx && n0 + i < 1024; i++) begin
      chk({name, "_xaddr"}, log_addr[n0 + i], BASE + 32'(4 * i));
      chk({name, "_xwrite"}, log_write[n0 + i], (i == 0));
      chk({name, "_xwdata"}, log_wdata[n0 + i], (i == 0) ? {16'h0, d} : 32'h0);
    end
    chk({name, "_acc_cycles"}, acc_total - a0, exp_acc);
    chk({name, "_stable"}, unstable - u0, 0);
    chk({name, "_fin_psel"}, fin_bad - f0, 0);
    $display("txn %s data=%04h status=%0d codeword=%010h latency=%0d transfers=%0d",
             name, d, status, codeword, k + 1, n_xfer - n0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ctl"}, {busy, done, status, PSEL, PENABLE, PWRITE}, 0);
    chk({name, "_cw"}, codeword, 0);
    chk({name, "_bus"}, {PADDR, PWDATA}, 0);
  endtask

  initial begin
    int r, k2;
    int w [3];
    bit e [3];
    logic [31:0] r2v;
    PRESETn = 1'b0; start = 1'b0; data_in = '0; exp_cw = '0;
    set_cfg(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    repeat (3) @(negedge PCLK);
    chk_zero("reset");
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk_zero("idle");

    set_cfg(0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h000000A5);
    run_txn("zero_wait", 16'h1234, 1'b0);
    chk("zero_wait_const", codeword, 40'hA5DEADBEEF);

    set_cfg(0, 3, 0, 0, 0, 0, 32'hDEADBEEF, 32'h000000A5);
    run_txn("wait_r1", 16'h1234, 1'b0);

    set_cfg(0, 0, 0, 1, 0, 0, 32'h11111111, 32'h00000022);
    run_txn("slverr_w", 16'h5A5A, 1'b0);

    set_cfg(1000, 0, 0, 0, 0, 0, 32'h11111111, 32'h00000022);
    run_txn("timeout_w", 16'hBEEF, 1'b0);

    set_cfg(0, 0, 0, 0, 0, 0, 32'h12345678, 32'h000001A5);
    run_txn("format", 16'h0F0F, 1'b0);

    set_cfg(0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 32'h0000003C);
    run_txn("busy_start", 16'h7777, 1'b1);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 3; i++) begin
        r = $urandom_range(0, 9);
        w[i] = (r < 7) ? int'($urandom_range(0, 3)) : (r == 7) ? TO - 1 : (r == 8) ? TO : 1000;
        e[i] = ($urandom_range(0, 9) == 0);
      end
      r2v = ($urandom_range(0, 3) == 0) ? $urandom : {24'h0, 8'($urandom)};
      set_cfg(w[0], w[1], w[2], e[0], e[1], e[2], $urandom, r2v);
      run_txn($sformatf("rand%0d", t), 16'($urandom), t[0]);
    end

    // reset while the low read is waiting
    set_cfg(0, 5, 0, 0, 0, 0, 32'h1, 32'h2);
    start = 1'b1; data_in = 16'hAAAA;
    @(negedge PCLK);
    start = 1'b0;
    k2 = 0;
    while (!(PSEL && PENABLE && PADDR == BASE + 32'd4) && k2 < 50) begin
      @(negedge PCLK);
      k2++;
    end
    chk("rst_reach_r1", (k2 < 50), 1);
    #2 PRESETn = 1'b0;
    #1 chk_zero("rst_mid");
    @(negedge PCLK);
    chk_zero("rst_hold");
    PRESETn = 1'b1;
    exp_cw = '0;
    @(negedge PCLK);
    chk("rst_no_done", {done, busy}, 0);
    $display("txn rst_mid reset applied during low read");

    set_cfg(0, 0, 0, 0, 0, 0, 32'h89ABCDEF, 32'h00000067);
    run_txn("after_rst", 16'hFFFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clc_apb_master.md
CLC_APB_MASTER -- requirements
Module: clc_apb_master

Interface
REQ-001 Parameters: BASE_ADDR, default 32'h0000_0000, APB base address of the CLC encoder peripheral.
REQ-002 Parameters: TIMEOUT, default 16, maximum access-phase cycles allowed with PREADY low (range 1..255).
REQ-003 The block SHALL use one clock, PCLK; reset PRESETn SHALL be asynchronous and active-low.
REQ-004 Ports SHALL be, one per entry: name, direction, width, meaning.
- PCLK  in  1  clock.
- PRESETn  in  1  async active-low reset.
- start  in  1  request one encode transaction.
- data_in  in  16  data word to encode.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- status  out  2  result: 0 ok, 1 slave error, 2 timeout, 3 format error.
- codeword  out  40  encoded result.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Function
REQ-005 States SHALL be IDLE, W_SETUP, W_ACCESS, R1_SETUP, R1_ACCESS, R2_SETUP, R2_ACCESS, FIN.
REQ-006 In IDLE with start=1, the block SHALL capture data_in, clear status, and enter W_SETUP; start while busy SHALL be ignored.
REQ-007 W_SETUP/W_ACCESS SHALL drive PADDR=BASE_ADDR+0, PWRITE=1, PWDATA={16'h0,data}.
REQ-008 R1 SHALL drive PADDR=BASE_ADDR+4 and R2 PADDR=BASE_ADDR+8, both with PWRITE=0 and PWDATA=0.
REQ-009 SETUP states SHALL drive PSEL=1, PENABLE=0, last exactly one cycle, and advance to the matching ACCESS state.
REQ-010 ACCESS states SHALL drive PSEL=1, PENABLE=1 and hold until PREADY=1, with PADDR, PWRITE and PWDATA stable for the whole transfer.
REQ-011 Transfers SHALL be back-to-back: PSEL stays 1 from W_SETUP through R2_ACCESS; PENABLE returns to 0 in every SETUP state.
REQ-012 On R1_ACCESS completion, PRDATA SHALL be stored in an internal low register; on R2_ACCESS completion, PRDATA[7:0] SHALL be stored in an internal high register.
REQ-013 codeword SHALL be updated to {high,low} only when all three transfers complete without error; it SHALL otherwise hold its previous value.
REQ-014 Format check: if R2 completes with PRDATA[31:8]!=0, status SHALL be 3 and codeword SHALL NOT be updated.
REQ-015 PSLVERR=1 together with PREADY=1 in any ACCESS state SHALL abort: status=1, go to FIN, and issue no further transfers.
REQ-016 A wait counter SHALL clear on entry to each ACCESS state and increment per cycle with PREADY=0; on reaching TIMEOUT it SHALL abort with status=2.
REQ-017 FIN SHALL drive PSEL=0, PENABLE=0, pulse done=1 for one cycle, then return to IDLE; status SHALL hold until the next accepted start.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 Latency with zero wait states SHALL be: start sampled at edge N, done=1 in cycle N+7; each wait cycle adds one.
REQ-020 PSEL and PENABLE SHALL be registered outputs with no combinational path from PRDATA, PREADY or PSLVERR.

Reset
REQ-021 While PRESETn=0 the block SHALL force state=IDLE and all outputs (busy, done, status, codeword, PADDR, PWDATA, PSEL, PENABLE, PWRITE) and internal registers to 0, immediately and asynchronously.
REQ-022 Reset mid-transaction SHALL drop PSEL immediately, with no done pulse, after which the block SHALL accept a new start normally.

Verification
REQ-023 Zero-wait: data_in=16'h1234 with the slave returning 32'hDEADBEEF at offset 4 and 32'h000000A5 at offset 8 -> write PWDATA=32'h00001234 to offset 0; codeword=40'hA5DEADBEEF; status=0; done at N+7.
REQ-024 Wait states: PREADY low for 3 cycles on R1 -> identical result with done at N+10 and PADDR stable throughout.
REQ-025 PSLVERR on the write transfer -> no reads issued, status=1, codeword unchanged, one done pulse.
REQ-026 PREADY stuck at 0 with TIMEOUT=16 -> abort after 16 wait cycles; status=2; PSEL=0 in FIN.
REQ-027 R2 returns 32'h000001A5 -> status=3 and codeword unchanged.
REQ-028 Reset asserted in R1_ACCESS -> all outputs 0 immediately; a following start with data_in=16'hFFFF completes normally.
